// File: rtl/regfile_wb_arbiter.sv
//==============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Three-way writeback arbiter for the register file write port.
//            Optional macro WB_ARB_RR_EN selects round-robin base priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic [2:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [2:0]        req_ready,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic [2:0]        starve_flag
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  logic [2:0][3:0]   r_cnt;
  logic [2:0]        r_flag;
  logic [2:0]        w_starved;
  logic [2:0]        w_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

`ifdef WB_ARB_RR_EN
  logic [1:0] r_ptr;
`endif

  assign w_starved = req_valid & r_flag;

  always_comb begin
    w_grant = 3'b000;
    if (!wb_stall) begin
      if      (w_starved[0]) w_grant = 3'b001;
      else if (w_starved[1]) w_grant = 3'b010;
      else if (w_starved[2]) w_grant = 3'b100;
      else begin
`ifdef WB_ARB_RR_EN
        // Search order rotates so the last winner is considered last.
        case (r_ptr)
          2'd1: begin
            if      (req_valid[1]) w_grant = 3'b010;
            else if (req_valid[2]) w_grant = 3'b100;
            else if (req_valid[0]) w_grant = 3'b001;
          end
          2'd2: begin
            if      (req_valid[2]) w_grant = 3'b100;
            else if (req_valid[0]) w_grant = 3'b001;
            else if (req_valid[1]) w_grant = 3'b010;
          end
          default: begin
            if      (req_valid[0]) w_grant = 3'b001;
            else if (req_valid[1]) w_grant = 3'b010;
            else if (req_valid[2]) w_grant = 3'b100;
          end
        endcase
`else
        if      (req_valid[0]) w_grant = 3'b001;
        else if (req_valid[1]) w_grant = 3'b010;
        else if (req_valid[2]) w_grant = 3'b100;
`endif
      end
    end
  end

  always_comb begin
    w_sel_addr = req_addr0;
    w_sel_data = req_data0;
    if (w_grant[1]) begin
      w_sel_addr = req_addr1;
      w_sel_data = req_data1;
    end else if (w_grant[2]) begin
      w_sel_addr = req_addr2;
      w_sel_data = req_data2;
    end
  end

  assign w_xfer      = |w_grant;
  assign req_ready   = w_grant;
  assign starve_flag = r_flag;

  always_ff @(posedge CLK) begin
    if (rst) begin
      WE3    <= 1'b0;
      A3     <= '0;
      WD3    <= '0;
      r_cnt  <= '0;
      r_flag <= 3'b000;
`ifdef WB_ARB_RR_EN
      r_ptr  <= 2'd0;
`endif
    end else if (wb_stall) begin
      WE3 <= 1'b0;
    end else begin
      // Register 0 is hardwired, so its writes are accepted but never enabled.
      WE3 <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        A3  <= w_sel_addr;
        WD3 <= w_sel_data;
      end
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || w_grant[i]) begin
          r_cnt[i]  <= 4'd0;
          r_flag[i] <= 1'b0;
        end else if (r_cnt[i] != c_starve_max) begin
          r_cnt[i]  <= r_cnt[i] + 4'd1;
          r_flag[i] <= ((r_cnt[i] + 4'd1) == c_starve_max);
        end
      end
`ifdef WB_ARB_RR_EN
      case (w_grant)
        3'b001:  r_ptr <= 2'd1;
        3'b010:  r_ptr <= 2'd2;
        3'b100:  r_ptr <= 2'd0;
        default: r_ptr <= r_ptr;
      endcase
`endif
    end
  end

endmodule

`default_nettype wire
